// File: rtl/keypad_input.sv
// keypad_input: scans a 4x4 active-low matrix keypad, debounces presses,
// accumulates a decimal entry and hands completed entries ('#') to the CPU
// through a valid/ack handshake with a sticky overrun flag.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// SCAN     | rotate the driven row each tick until a column reads low
// DEBOUNCE | row frozen, waiting for the latched column to stay low
// HELD     | key accepted, row frozen, waiting for a full debounced release
module keypad_input #(
  parameter int SCAN_DIV       = 100_000,
  parameter int DEBOUNCE_TICKS = 10,
  parameter int MAX_DIGITS     = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_col_in,
  output logic [3:0]  key_row_out,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [23:0] entry_value,
  output logic [3:0]  entry_digits,
  output logic [23:0] data_out,
  output logic        data_valid,
  input  logic        data_ack,
  output logic        overrun
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_TICKS + 1);

  localparam logic [DIV_W-1:0] DIV_LOAD  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_FULL   = DB_W'(DEBOUNCE_TICKS);
  localparam logic [DB_W-1:0]  DB_PRESS  = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);
  localparam logic [3:0]       MAX_N     = 4'(MAX_DIGITS);
  localparam bit               DB_SINGLE = (DEBOUNCE_TICKS == 1);

  localparam logic [3:0] CODE_CLEAR = 4'hA;
  localparam logic [3:0] CODE_BACK  = 4'hE;
  localparam logic [3:0] CODE_ENTER = 4'hF;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       col_meta;
  logic [3:0]       col_sync;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [1:0]       row_idx;
  logic [1:0]       key_col;
  logic [DB_W-1:0]  db_cnt;
  logic             col_any;
  logic [1:0]       col_idx;
  logic             col_same;
  logic [23:0]      entry_mac;
  logic             is_digit;
  logic             enter_key;
  logic             commit_ok;
  logic             overrun_set;

  // Row/column position to key code.
  function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = 4'hE;
      4'hD:    code = 4'h0;
      4'hE:    code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Two-flop synchroniser for the asynchronous column inputs (idle high).
  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= key_col_in;
      col_sync <= col_meta;
    end
  end

  // Scan-tick divider: down-counter, tick on terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= DIV_LOAD;
    end else if (div_cnt == '0) begin
      div_cnt <= DIV_LOAD;
    end else begin
      div_cnt <= div_cnt - DIV_W'(1);
    end
  end

  assign tick = (div_cnt == '0) && !rst;

  // Lowest-index low column wins when several keys share the row.
  always_comb begin
    col_any = (col_sync != 4'hF);
    col_idx = 2'd3;
    if (!col_sync[0]) begin
      col_idx = 2'd0;
    end else if (!col_sync[1]) begin
      col_idx = 2'd1;
    end else if (!col_sync[2]) begin
      col_idx = 2'd2;
    end
    col_same = col_any && (col_idx == key_col);
  end

  // Scan / debounce / release FSM; db_cnt counts remaining stable ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_SCAN;
      key_row_out <= 4'b1110;
      row_idx     <= 2'd0;
      key_col     <= 2'd0;
      db_cnt      <= '0;
      key_valid   <= 1'b0;
      key_code    <= 4'h0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          ST_SCAN: begin
            if (col_any) begin
              key_col <= col_idx;
              if (DB_SINGLE) begin
                key_valid <= 1'b1;
                key_code  <= map_key(row_idx, col_idx);
                db_cnt    <= DB_FULL;
                state     <= ST_HELD;
              end else begin
                db_cnt <= DB_PRESS;
                state  <= ST_DEBOUNCE;
              end
            end else begin
              key_row_out <= {key_row_out[2:0], key_row_out[3]};
              row_idx     <= row_idx + 2'd1;
            end
          end
          ST_DEBOUNCE: begin
            if (!col_same) begin
              state <= ST_SCAN;
            end else if (db_cnt == DB_ONE) begin
              key_valid <= 1'b1;
              key_code  <= map_key(row_idx, key_col);
              db_cnt    <= DB_FULL;
              state     <= ST_HELD;
            end else begin
              db_cnt <= db_cnt - DB_ONE;
            end
          end
          ST_HELD: begin
            if (col_any) begin
              db_cnt <= DB_FULL;
            end else if (db_cnt == DB_ONE) begin
              state       <= ST_SCAN;
              key_row_out <= {key_row_out[2:0], key_row_out[3]};
              row_idx     <= row_idx + 2'd1;
            end else begin
              db_cnt <= db_cnt - DB_ONE;
            end
          end
          default: begin
            state <= ST_SCAN;
          end
        endcase
      end
    end
  end

  // Entry decode; E*10+d is formed wide and truncated to 24 bits.
  always_comb begin
    entry_mac   = 24'(28'(entry_value) * 28'd10 + 28'(key_code));
    is_digit    = (key_code <= 4'd9);
    enter_key   = key_valid && (key_code == CODE_ENTER);
    commit_ok   = enter_key && (!data_valid || data_ack);
    overrun_set = enter_key && data_valid && !data_ack;
  end

  // Live entry update, one clock after the accepted key.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_value  <= 24'd0;
      entry_digits <= 4'd0;
    end else if (key_valid) begin
      if (is_digit) begin
        if (entry_digits < MAX_N) begin
          entry_value <= entry_mac;
          if (!((entry_value == 24'd0) && (key_code == 4'd0))) begin
            entry_digits <= entry_digits + 4'd1;
          end
        end
      end else if (key_code == CODE_CLEAR) begin
        entry_value  <= 24'd0;
        entry_digits <= 4'd0;
      end else if (key_code == CODE_BACK) begin
        entry_value <= entry_value / 24'd10;
        if (entry_digits != 4'd0) begin
          entry_digits <= entry_digits - 4'd1;
        end
      end else if (commit_ok) begin
        entry_value  <= 24'd0;
        entry_digits <= 4'd0;
      end
    end
  end

  // Commit handshake; an ack in the same clock frees the slot for the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= 24'd0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit_ok) begin
      data_out   <= entry_value;
      data_valid <= 1'b1;
      overrun    <= 1'b0;
    end else if (overrun_set) begin
      overrun <= 1'b1;
    end else if (data_ack && data_valid) begin
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_input.sv
// Bench for keypad_input: keypad model, decimal-entry reference model and
// a scoreboard checked by an independent monitor on every key_valid.
module tb_keypad_input;

  localparam int SD = 4;
  localparam int DT = 3;
  localparam int MD = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_col_in;
  logic [3:0]  key_row_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [23:0] entry_value;
  logic [3:0]  entry_digits;
  logic [23:0] data_out;
  logic        data_valid;
  logic        data_ack;
  logic        overrun;

  keypad_input #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT), .MAX_DIGITS(MD)) dut (
    .clk(clk), .rst(rst), .key_col_in(key_col_in), .key_row_out(key_row_out),
    .key_valid(key_valid), .key_code(key_code), .entry_value(entry_value),
    .entry_digits(entry_digits), .data_out(data_out), .data_valid(data_valid),
    .data_ack(data_ack), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Keypad: the pressed key pulls its column low while its row is driven low.
  logic       pressed;
  logic [1:0] p_row;
  logic [1:0] p_col;

  always_comb begin
    key_col_in = 4'hF;
    if (pressed && (key_row_out[p_row] == 1'b0)) key_col_in[p_col] = 1'b0;
  end

  int keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

  typedef struct {
    int code;
    int ev;
    int nd;
    int dv;
    int dout;
    int ovr;
  } exp_t;

  exp_t sbq[$];

  int dq[$];
  int m_dv;
  int m_dout;
  int m_ovr;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic int m_value();
    int v;
    v = 0;
    foreach (dq[i]) v = v * 10 + dq[i];
    return v;
  endfunction

  task automatic m_reset();
    dq.delete();
    m_dv = 0;
    m_dout = 0;
    m_ovr = 0;
  endtask

  task automatic m_apply(input int code);
    if (code <= 9) begin
      if (dq.size() < MD && !(dq.size() == 0 && code == 0)) dq.push_back(code);
    end else if (code == 10) begin
      dq.delete();
    end else if (code == 14) begin
      if (dq.size() > 0) void'(dq.pop_back());
    end else if (code == 15) begin
      if (m_dv == 0) begin
        m_dout = m_value();
        m_dv = 1;
        m_ovr = 0;
        dq.delete();
      end else begin
        m_ovr = 1;
      end
    end
  endtask

  task automatic ticks(input int n);
    repeat (n * SD) @(negedge clk);
  endtask

  task automatic set_key(input int code);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keymap[r][c] == code) begin
          p_row = 2'(r);
          p_col = 2'(c);
        end
  endtask

  task automatic press_key(input int code, input int hold, input int rel, input bit expect_ev);
    exp_t e;
    if (expect_ev) begin
      m_apply(code);
      e = '{code, m_value(), dq.size(), m_dv, m_dout, m_ovr};
      sbq.push_back(e);
    end
    set_key(code);
    pressed = 1'b1;
    ticks(hold);
    chk("event_pending_after_hold", sbq.size(), 0);
    pressed = 1'b0;
    ticks(rel);
  endtask

  task automatic ack_pulse();
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    if (m_dv != 0) begin
      m_dv = 0;
      m_ovr = 0;
    end
    chk("ack_data_valid", data_valid, m_dv);
    chk("ack_overrun", overrun, m_ovr);
  endtask

  task automatic wait_row(input logic [3:0] r, input string nm);
    int n;
    n = 0;
    while (key_row_out !== r && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(nm, key_row_out, r);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_row"}, key_row_out, 4'b1110);
    chk({tag, "_key_valid"}, key_valid, 0);
    chk({tag, "_key_code"}, key_code, 0);
    chk({tag, "_entry_value"}, entry_value, 0);
    chk({tag, "_entry_digits"}, entry_digits, 0);
    chk({tag, "_data_out"}, data_out, 0);
    chk({tag, "_data_valid"}, data_valid, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  // Monitor: every key_valid must match the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (key_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_key_valid: got key_code %0d, expected no event", key_code);
        end else begin
          e = sbq.pop_front();
          chk("key_code", key_code, e.code);
          @(negedge clk);
          chk("key_valid_width", key_valid, 0);
          chk("entry_value", entry_value, e.ev);
          chk("entry_digits", entry_digits, e.nd);
          chk("data_valid", data_valid, e.dv);
          chk("data_out", data_out, e.dout);
          chk("overrun", overrun, e.ovr);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int code;
    int seq2 [6] = '{10, 1, 2, 3, 14, 4};
    int seq3 [5] = '{10, 0, 0, 7, 15};
    rst = 1'b1;
    data_ack = 1'b0;
    pressed = 1'b0;
    p_row = 2'd0;
    p_col = 2'd0;
    m_reset();
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;
    ticks(2);

    // Press '5' with a one-tick bounce first.
    set_key(5);
    pressed = 1'b1;
    ticks(1);
    pressed = 1'b0;
    ticks(1);
    press_key(5, 10, 6, 1'b1);
    chk("t1_entry_value", entry_value, 5);
    chk("t1_entry_digits", entry_digits, 1);

    // Clear then 1,2,3,*,4.
    foreach (seq2[i]) press_key(seq2[i], 10, 6, 1'b1);
    chk("t2_entry_value", entry_value, 124);
    chk("t2_entry_digits", entry_digits, 3);

    // Clear then 0,0,7,#.
    foreach (seq3[i]) press_key(seq3[i], 10, 6, 1'b1);
    chk("t3_data_out", data_out, 7);
    chk("t3_data_valid", data_valid, 1);
    chk("t3_entry_value", entry_value, 0);
    chk("t3_entry_digits", entry_digits, 0);
    ack_pulse();
    chk("t3_valid_after_ack", data_valid, 0);

    // Eight 9s, then # twice without ack.
    repeat (8) press_key(9, 10, 6, 1'b1);
    chk("t4_entry_value", entry_value, 9_999_999);
    chk("t4_entry_digits", entry_digits, 7);
    press_key(15, 10, 6, 1'b1);
    press_key(15, 10, 6, 1'b1);
    chk("t4_data_out", data_out, 9_999_999);
    chk("t4_data_valid", data_valid, 1);
    chk("t4_overrun", overrun, 1);
    ack_pulse();
    chk("t4_valid_after_ack", data_valid, 0);
    chk("t4_overrun_after_ack", overrun, 0);

    // Long hold of '2'; 'A' pressed before release debounce completes gives no event.
    press_key(2, 50, 1, 1'b1);
    press_key(10, 10, 8, 1'b0);
    chk("t5_entry_value", entry_value, 2);
    chk("t5_entry_digits", entry_digits, 1);

    // Reset while '8' is debouncing.
    wait_row(4'b1101, "t6_wait_row1");
    set_key(8);
    pressed = 1'b1;
    wait_row(4'b1011, "t6_wait_row2");
    repeat (SD) @(negedge clk);
    rst = 1'b1;
    pressed = 1'b0;
    @(negedge clk);
    chk_reset_state("t6");
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    ticks(8);
    chk("t6_no_event", entry_digits, 0);

    // Random keys with occasional acks.
    for (int n = 0; n < 40; n++) begin
      code = int'($urandom_range(0, 15));
      press_key(code, int'($urandom_range(10, 14)), int'($urandom_range(6, 8)), 1'b1);
      if ($urandom_range(0, 3) == 0) ack_pulse();
    end

    ticks(4);
    chk("queue_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
